// File: rtl/simple_bus_master.sv
// simple_bus_master: queues read/write commands and issues them one at a time on a req/ack slave bus.
// Latency: req rises 2 edges after an idle enqueue; the response is valid the edge after ack; one transaction is in flight.
// Backpressure: cmd_ready drops while the FIFO is full; the response is held until rsp_ready. Option: SIMPLE_BUS_MASTER_TIMEOUT_EN.
module simple_bus_master #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_wr,
    input  logic [7:0]               cmd_addr,
    input  logic [7:0]               cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_wr,
    output logic [7:0]               rsp_rdata,
    output logic                     rsp_err,
    output logic                     req,
    output logic                     wr1rd0,
    output logic [7:0]               addr,
    output logic [7:0]               data,
    input  logic                     ack,
    input  logic [7:0]               rd_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   cmd_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [16:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_done;
    logic          w_expire;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid && !w_full;
    assign cmd_ready = !w_full;
    assign cmd_count = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {cmd_wr, cmd_addr, cmd_wdata};
    end

`ifdef SIMPLE_BUS_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_to_cnt <= '0;
        else if (w_pop)
            r_to_cnt <= '0;
        else if (r_state == S_REQ && !ack)
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    // Expiry excludes ack so a late ack on the final cycle still completes normally.
    assign w_expire = (r_state == S_REQ) && !ack && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_expire = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: if (!w_empty) begin
                w_pop  = 1'b1;
                w_next = S_REQ;
            end
            S_REQ: if (ack || w_expire) begin
                w_done = 1'b1;
                w_next = S_RSP;
            end
            S_RSP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr1rd0    <= 1'b0;
            addr      <= 8'h00;
            data      <= 8'h00;
            rsp_wr    <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
        end else begin
            if (w_pop) {wr1rd0, addr, data} <= r_mem[r_rptr];
            if (w_done) begin
                rsp_wr    <= wr1rd0;
                rsp_err   <= w_expire;
                rsp_rdata <= (!wr1rd0 && !w_expire) ? rd_data : 8'h00;
            end
        end
    end

    assign req       = (r_state == S_REQ);
    assign rsp_valid = (r_state == S_RSP);
    assign busy      = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_simple_bus_master.sv
// Bench for simple_bus_master: bus slave model, in-order command/response reference model and directed scenarios.
`timescale 1ns/1ps
module tb_simple_bus_master;
    localparam int DEPTH          = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_wr, rsp_err;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       req, wr1rd0;
    logic [7:0] addr, data, rd_data;
    logic       ack = 1'b0;
    logic       busy;
    logic [2:0] cmd_count;

    simple_bus_master #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .req(req), .wr1rd0(wr1rd0), .addr(addr), .data(data),
        .ack(ack), .rd_data(rd_data), .busy(busy), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register/memory slave: addr 0x01 resets to 0x10, addr 0x02 has bits 7:6 read-only at 01.
    logic [7:0] smem [256];
    assign rd_data = smem[addr];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++)
                smem[i] <= (i == 1) ? 8'h10 : (i == 2) ? 8'h40 : 8'h00;
        end else if (req && ack && wr1rd0) begin
            smem[addr] <= (addr == 8'h02) ? {2'b01, data[5:0]} : data;
        end
    end

    int ack_mode = 1;   // 0 random, 1 always, 2 never
    int rr_mode  = 1;
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            1:       ack = 1'b1;
            2:       ack = 1'b0;
            default: ack = ($urandom_range(0, 3) != 0);
        endcase
        case (rr_mode)
            1:       rsp_ready = 1'b1;
            2:       rsp_ready = 1'b0;
            default: rsp_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Reference model: commands complete strictly in acceptance order, so every
    // response is known the moment its command is accepted.
    logic [7:0]  mmem [256];
    logic [9:0]  exp_q[$];      // {wr, rdata, err}
    logic [16:0] bus_q[$];      // {wr, addr, wdata}
    int          n_acc = 0, n_iss = 0, n_done = 0, req_cycles = 0;
    logic        prev_req = 0, prev_ack = 0, prev_rv = 0, prev_rr = 0, prev_idle_nz = 0, to_pending = 0;
    logic [16:0] prev_bus = '0;
    logic [9:0]  prev_rsp = '0;
    logic [16:0] b;
    logic [9:0]  e;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            bus_q.delete();
            n_acc = 0; n_iss = 0; n_done = 0; req_cycles = 0;
            prev_req = 0; prev_ack = 0; prev_rv = 0; prev_rr = 0; prev_idle_nz = 0; to_pending = 0;
            for (int i = 0; i < 256; i++)
                mmem[i] = (i == 1) ? 8'h10 : (i == 2) ? 8'h40 : 8'h00;
        end else begin
            if (prev_req && prev_ack) begin
                chk("ack_gives_rsp_valid", rsp_valid, 1);
                chk("ack_drops_req", req, 0);
            end else if (to_pending) begin
                chk("timeout_drops_req", req, 0);
                chk("timeout_rsp_valid", rsp_valid, 1);
            end else if (prev_req) begin
                chk("req_held", req, 1);
                chk("bus_stable", {wr1rd0, addr, data}, prev_bus);
            end
            if (prev_rv && prev_rr) begin
                chk("rsp_exit_valid", rsp_valid, 0);
                chk("rsp_exit_req", req, 0);
            end else if (prev_rv) begin
                chk("rsp_hold_valid", rsp_valid, 1);
                chk("rsp_hold_data", {rsp_wr, rsp_rdata, rsp_err}, prev_rsp);
            end
            if (prev_idle_nz) chk("idle_pop_req", req, 1);
            if (req && !prev_req) begin
                chk("bus_cmd_expected", bus_q.size() != 0, 1);
                if (bus_q.size() != 0) begin
                    b = bus_q.pop_front();
                    chk("bus_wr1rd0", wr1rd0, b[16]);
                    chk("bus_addr", addr, b[15:8]);
                    if (b[16]) chk("bus_data", data, b[7:0]);
                    n_iss++;
                end
                req_cycles = 0;
            end
            if (req) req_cycles++;
            chk("one_outstanding", req && rsp_valid, 0);
            chk("cmd_count", cmd_count, n_acc - n_iss);
            chk("cmd_ready", cmd_ready, (n_acc - n_iss) != DEPTH);
            chk("busy", busy, n_acc != n_done);

            to_pending = 0;
`ifdef SIMPLE_BUS_MASTER_TIMEOUT_EN
            if (req && !ack && req_cycles == TIMEOUT_CYCLES) begin
                to_pending = 1;
                if (exp_q.size() != 0) exp_q[0] = {exp_q[0][9], 8'h00, 1'b1};
            end
`endif
            if (rsp_valid) begin
                chk("rsp_expected", exp_q.size() != 0, 1);
                if (rsp_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_wr", rsp_wr, e[9]);
                    chk("rsp_rdata", rsp_rdata, e[8:1]);
                    chk("rsp_err", rsp_err, e[0]);
                    n_done++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_wr) begin
                    mmem[cmd_addr] = (cmd_addr == 8'h02) ? {2'b01, cmd_wdata[5:0]} : cmd_wdata;
                    exp_q.push_back({1'b1, 8'h00, 1'b0});
                end else begin
                    exp_q.push_back({1'b0, mmem[cmd_addr], 1'b0});
                end
                bus_q.push_back({cmd_wr, cmd_addr, cmd_wdata});
                n_acc++;
            end
            prev_req     = req;
            prev_ack     = ack;
            prev_rv      = rsp_valid;
            prev_rr      = rsp_ready;
            prev_bus     = {wr1rd0, addr, data};
            prev_rsp     = {rsp_wr, rsp_rdata, rsp_err};
            prev_idle_nz = !req && !rsp_valid && (cmd_count != 0);
        end
    end

    task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
        bit ok = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_wdata = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) chk("push_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic w, input logic [7:0] rd, input logic er);
        bit ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        chk({name, "_seen"}, ok, 1);
        if (ok) begin
            chk({name, "_wr"}, rsp_wr, w);
            chk({name, "_rdata"}, rsp_rdata, rd);
            chk({name, "_err"}, rsp_err, er);
        end
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!rsp_valid) break;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req", req, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_cmd_count", cmd_count, 0);
        chk("reset_addr", addr, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1);

        push(1'b0, 8'h01, 8'h00);
        @(negedge clk);
        chk("lat_req_n", req, 0);
        chk("lat_count_n", cmd_count, 1);
        @(negedge clk);
        chk("lat_req_n1", req, 1);
        wait_rsp("rd01", 1'b0, 8'h10, 1'b0);

        push(1'b1, 8'h00, 8'hA5);
        push(1'b0, 8'h00, 8'h00);
        wait_rsp("wr00", 1'b1, 8'h00, 1'b0);
        wait_rsp("rd00", 1'b0, 8'hA5, 1'b0);

        push(1'b1, 8'h02, 8'hFF);
        push(1'b0, 8'h02, 8'h00);
        wait_rsp("wr02", 1'b1, 8'h00, 1'b0);
        wait_rsp("rd02", 1'b0, 8'h7F, 1'b0);

        rr_mode = 2;
        push(1'b1, 8'h10, 8'h11);
        push(1'b1, 8'h11, 8'h22);
        push(1'b0, 8'h10, 8'h00);
        push(1'b0, 8'h11, 8'h00);
        push(1'b1, 8'h08, 8'h3C);
        repeat (3) @(negedge clk);
        chk("full_count", cmd_count, DEPTH);
        chk("full_ready", cmd_ready, 0);
        chk("full_rsp_valid", rsp_valid, 1);
        chk("full_rsp_wr", rsp_wr, 1);
        rr_mode = 1;
        push(1'b0, 8'h08, 8'h00);
        wait_rsp("fill_w11", 1'b1, 8'h00, 1'b0);
        wait_rsp("fill_r10", 1'b0, 8'h11, 1'b0);
        wait_rsp("fill_r11", 1'b0, 8'h22, 1'b0);
        wait_rsp("fill_w08", 1'b1, 8'h00, 1'b0);
        wait_rsp("fill_r08", 1'b0, 8'h3C, 1'b0);

        ack_mode = 2;
        push(1'b0, 8'h01, 8'h00);
        push(1'b0, 8'h01, 8'h00);
        push(1'b0, 8'h01, 8'h00);
        @(posedge clk);
        #2;
        chk("pre_reset_req", req, 1);
        chk("pre_reset_count", cmd_count, 2);
        reset = 1'b1;
        #1;
        chk("async_reset_req", req, 0);
        chk("async_reset_count", cmd_count, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ack_mode = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", rsp_valid, 0);
        end

        ack_mode = 0;
        rr_mode  = 0;
        for (int i = 0; i < 300; i++) begin
            n = $urandom_range(0, 7);
            push($urandom_range(0, 1) == 1, (n < 4) ? 8'(n) : 8'(n + 4), 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (n_done == n_acc && !busy) begin ok = 1; break; end
        end
        chk("random_drained", ok, 1);

`ifdef SIMPLE_BUS_MASTER_TIMEOUT_EN
        ack_mode = 2;
        rr_mode  = 1;
        push(1'b0, 8'h05, 8'h00);
        for (int t = 0; t < 50; t++) begin
            if (req) break;
            @(negedge clk);
        end
        n = 0;
        while (req && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", n, TIMEOUT_CYCLES);
        chk("timeout_rsp_valid_lit", rsp_valid, 1);
        chk("timeout_rsp_err_lit", rsp_err, 1);
        chk("timeout_rsp_rdata_lit", rsp_rdata, 0);
        ack_mode = 1;
        repeat (4) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
